// File: rtl/rv_exec_pkg.sv
// Shared constants for the RV32I execute stage: datapath width, one-hot ALU
// op bit positions, PC step and the major opcodes the front-end decoder uses.
package rv_exec_pkg;

  localparam int unsigned XLEN = 32;

  // Bit positions inside the one-hot alu_op vector.
  localparam int unsigned OP_AUIPC = 0;
  localparam int unsigned OP_LUI   = 1;
  localparam int unsigned OP_JAL   = 2;
  localparam int unsigned OP_JALR  = 3;
  localparam int unsigned OP_ADDI  = 4;
  localparam int unsigned OP_ADD   = 5;
  localparam int unsigned OP_LW    = 6;
  localparam int unsigned NUM_OPS  = 7;

  localparam int unsigned PC_INC = 4;

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

endpackage

// File: rtl/rv_exec_regfile.sv
// General-purpose register file: two combinational read ports, one write port,
// asynchronous active-low clear, x0 hard-wired to zero, no write-to-read bypass.
// Build option: define RV32E_EN to shrink the file to x0-x15; accesses to
// x16-x31 then write nothing and read zero.
module rv_exec_regfile #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       NREGS     = 32,
  parameter logic [XLEN-1:0]   RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

`ifdef RV32E_EN
  localparam int unsigned NumRegs = (NREGS < 16) ? NREGS : 16;
`else
  localparam int unsigned NumRegs = NREGS;
`endif
  localparam int unsigned IdxW = $clog2(NumRegs);

  logic [XLEN-1:0] regs_q [NumRegs];
  logic [XLEN-1:0] regs_d [NumRegs];

  logic waddr_ok, raddr1_ok, raddr2_ok;

  // Address qualification: x0 and registers outside the implemented file.
  always_comb begin
    waddr_ok  = (waddr  != 5'd0) && (32'(waddr)  < NumRegs);
    raddr1_ok = (raddr1 != 5'd0) && (32'(raddr1) < NumRegs);
    raddr2_ok = (raddr2 != 5'd0) && (32'(raddr2) < NumRegs);
  end

  // Next-state: only the addressed register changes on a qualified write.
  always_comb begin
    regs_d = regs_q;
    if (wen && waddr_ok) begin
      regs_d[waddr[IdxW-1:0]] = wdata;
    end
  end

  // Storage with asynchronous clear; reset also blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads; the old value is seen until the write edge.
  always_comb begin
    rdata1 = raddr1_ok ? regs_q[raddr1[IdxW-1:0]] : '0;
    rdata2 = raddr2_ok ? regs_q[raddr2[IdxW-1:0]] : '0;
  end

endmodule

// File: rtl/rv_exec_unit.sv
// Execute stage of the single-cycle RV32I core: register file, funct3 one-hot
// decoder and one-hot-op ALU producing the writeback value and next PC.
// The writeback value loops back into the register file write port.
// Build option: RV32E_EN (16-entry register file, see rv_exec_regfile).
module rv_exec_unit #(
  parameter int unsigned     XLEN      = rv_exec_pkg::XLEN,
  parameter int unsigned     NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  output logic [7:0]      funct3_hot,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            reg_wen,
  input  logic [6:0]      alu_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] next_pc
);

  import rv_exec_pkg::*;

  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] src1_imm;
  logic [XLEN-1:0] src1_src2;
  logic [XLEN-1:0] jalr_tgt;
  logic            seq_en;
  logic            link_en;

  rv_exec_regfile #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wen    (reg_wen),
    .waddr  (rd),
    .wdata  (result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (src1),
    .rdata2 (src2)
  );

  // funct3 one-hot decode.
  always_comb begin
    funct3_hot = 8'd1 << funct3;
  end

  // Shared adders for the ALU terms.
  always_comb begin
    pc_seq    = pc + XLEN'(PC_INC);
    pc_imm    = pc + imm;
    src1_imm  = src1 + imm;
    src1_src2 = src1 + src2;
    jalr_tgt  = {src1_imm[XLEN-1:1], 1'b0};
  end

  // One-hot ALU: each enabled op ORs in its term, no priority between ops.
  // alu_op == 0 falls through to result 0 and a sequential next PC.
  always_comb begin
    link_en = alu_op[OP_JAL] | alu_op[OP_JALR];
    seq_en  = alu_op[OP_AUIPC] | alu_op[OP_LUI] | alu_op[OP_ADDI] | alu_op[OP_ADD] |
              alu_op[OP_LW] | (alu_op == 7'd0);

    result = ({XLEN{alu_op[OP_AUIPC]}} & pc_imm)    |
             ({XLEN{alu_op[OP_LUI]}}   & imm)       |
             ({XLEN{link_en}}          & pc_seq)    |
             ({XLEN{alu_op[OP_ADDI]}}  & src1_imm)  |
             ({XLEN{alu_op[OP_ADD]}}   & src1_src2) |
             ({XLEN{alu_op[OP_LW]}}    & rdata);

    next_pc = ({XLEN{seq_en}}          & pc_seq) |
              ({XLEN{alu_op[OP_JAL]}}  & pc_imm) |
              ({XLEN{alu_op[OP_JALR]}} & jalr_tgt);
  end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: directed cases plus random ops,
// compared against an architectural register/ALU model.
module tb_rv_exec_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  funct3;
  logic [7:0]  funct3_hot;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_wen;
  logic [6:0]  alu_op;
  logic [31:0] imm, pc, rdata;
  logic [31:0] src1, src2, result, next_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  rv_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .funct3     (funct3),
    .funct3_hot (funct3_hot),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .reg_wen    (reg_wen),
    .alu_op     (alu_op),
    .imm        (imm),
    .pc         (pc),
    .rdata      (rdata),
    .src1       (src1),
    .src2       (src2),
    .result     (result),
    .next_pc    (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef RV32E_EN
    if (a >= 5'd16) return 32'd0;
`endif
    return model[a];
  endfunction

  function automatic bit reg_writable(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef RV32E_EN
    if (a >= 5'd16) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // k: 0 auipc, 1 lui, 2 jal, 3 jalr, 4 addi, 5 add, 6 lw, 7 no op.
  task automatic do_op(input int k, input logic [4:0] rd_a, input logic [4:0] rs1_a,
                       input logic [4:0] rs2_a, input logic wen, input logic [31:0] imm_v,
                       input logic [31:0] pc_v, input logic [31:0] rdata_v,
                       input logic [2:0] f3);
    logic [31:0] s1, s2, er, en;
    @(negedge clk);
    alu_op  = (k == 7) ? 7'd0 : 7'(1 << k);
    rd      = rd_a;
    rs1     = rs1_a;
    rs2     = rs2_a;
    reg_wen = wen;
    imm     = imm_v;
    pc      = pc_v;
    rdata   = rdata_v;
    funct3  = f3;
    #1;
    s1 = reg_rd(rs1_a);
    s2 = reg_rd(rs2_a);
    en = pc_v + 32'd4;
    er = 32'd0;
    case (k)
      0: er = pc_v + imm_v;
      1: er = imm_v;
      2: begin er = pc_v + 32'd4; en = pc_v + imm_v; end
      3: begin er = pc_v + 32'd4; en = (s1 + imm_v) & 32'hFFFF_FFFE; end
      4: er = s1 + imm_v;
      5: er = s1 + s2;
      6: er = rdata_v;
      default: er = 32'd0;
    endcase
    check_eq($sformatf("src1[x%0d]", rs1_a), src1, s1);
    check_eq($sformatf("src2[x%0d]", rs2_a), src2, s2);
    check_eq($sformatf("result(op%0d)", k), result, er);
    check_eq($sformatf("next_pc(op%0d)", k), next_pc, en);
    check_eq($sformatf("funct3_hot(%0d)", f3), {24'd0, funct3_hot}, 32'd1 << f3);
    @(posedge clk);
    if (wen && reg_writable(rd_a)) model[rd_a] = er;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst = 1'b0; funct3 = 3'd0; rs1 = 5'd1; rs2 = 5'd31; rd = 5'd0; reg_wen = 1'b0;
    alu_op = 7'd0; imm = 32'd0; pc = 32'd0; rdata = 32'd0;
    #2;
    check_eq("reset_src1", src1, 32'd0);
    check_eq("reset_src2", src2, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-cycle after writing x5.
    do_op(1, 5'd5, 5'd0, 5'd0, 1'b1, 32'h0000_1234, 32'h100, 32'd0, 3'd0);
    @(negedge clk);
    reg_wen = 1'b0; alu_op = 7'd0; rs1 = 5'd5;
    #1;
    check_eq("pre_reset_x5", src1, 32'h0000_1234);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset_x5", src1, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    do_op(4, 5'd3, 5'd0, 5'd0, 1'b1, 32'h0000_07FF, 32'h200, 32'd0, 3'd1);
    do_op(5, 5'd0, 5'd3, 5'd3, 1'b1, 32'd0, 32'h204, 32'd0, 3'd2);
    do_op(7, 5'd0, 5'd3, 5'd0, 1'b0, 32'd0, 32'h208, 32'd0, 3'd3);
    check_eq("x3_value", src1, 32'h0000_07FF);
    do_op(1, 5'd4, 5'd0, 5'd0, 1'b1, 32'h1234_5000, 32'h20C, 32'd0, 3'd4);
    do_op(0, 5'd6, 5'd4, 5'd0, 1'b1, 32'h0000_1000, 32'h8000_0000, 32'd0, 3'd5);
    do_op(2, 5'd1, 5'd6, 5'd0, 1'b1, 32'hFFFF_FFF0, 32'h8000_0010, 32'd0, 3'd6);
    do_op(1, 5'd7, 5'd1, 5'd0, 1'b1, 32'h8000_0101, 32'h8000_0000, 32'd0, 3'd7);
    do_op(3, 5'd7, 5'd7, 5'd1, 1'b1, 32'd0, 32'h8000_0004, 32'd0, 3'd0);
    do_op(6, 5'd8, 5'd7, 5'd0, 1'b1, 32'd0, 32'h8000_0100, 32'hDEAD_BEEF, 3'd1);
    do_op(7, 5'd9, 5'd8, 5'd0, 1'b1, 32'h5555_5555, 32'h8000_0104, 32'h1111_1111, 3'd2);
    do_op(4, 5'd10, 5'd8, 5'd9, 1'b1, 32'd1, 32'hFFFF_FFFC, 32'd0, 3'd3);
    do_op(1, 5'd17, 5'd10, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0, 32'd0, 3'd4);
    do_op(7, 5'd0, 5'd17, 5'd17, 1'b0, 32'd0, 32'h4, 32'd0, 3'd5);
    for (int f = 0; f < 8; f++) begin
      do_op(7, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'h10, 32'd0, 3'(f));
    end

    // Random ops against the model.
    for (int n = 0; n < 300; n++) begin
      do_op(int'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
